// File: rtl/masked_sbox_pipe_ctrl.sv
// Purpose: lockstep controller for the 3-stage masked GF(2^8) S-box pipeline (enable, PRNG metering, valid/tag).
// Latency: a byte accepted in cycle k shows out_valid in cycle k+3; one byte per cycle sustained.
// Backpressure: whole pipe freezes (no enable, no PRNG word) on PRNG starvation or a blocked stage-3 result.
// Optional macro SBOX_CTRL_STALL_CNT_EN adds the saturating out_stall_cnt counter.
module masked_sbox_pipe_ctrl #(
  parameter int NUM_SHARES = 2,
  parameter int RAND_WIDTH = 64,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_valid,
  output logic                  out_in_ready,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  in_rand_valid,
  output logic                  out_rand_ready,
  input  logic [RAND_WIDTH-1:0] in_rand,
  output logic [RAND_WIDTH-1:0] out_random,
  output logic                  out_stage_en,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [TAG_WIDTH-1:0]  out_tag,
  input  logic                  in_flush,
  output logic                  out_busy
`ifdef SBOX_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]           out_stall_cnt
`endif
);

  // Per-stage side-band state; the shares themselves live in the datapath registers.
  typedef struct packed {
    logic                 vld;
    logic [TAG_WIDTH-1:0] tag;
  } stage_t;

  stage_t s1, s2, s3;

  logic shift_needed;
  logic out_sink;
  logic advance;

  // A shift is only worth a PRNG word if something valid would move.
  always_comb begin
    shift_needed = in_valid | s1.vld | s2.vld;
    out_sink     = ~s3.vld | in_ready;
    advance      = shift_needed & in_rand_valid & out_sink & ~in_flush;
  end

  assign out_stage_en   = advance;
  assign out_rand_ready = advance;
  assign out_in_ready   = advance;
  assign out_random     = in_rand;
  assign out_valid      = s3.vld;
  assign out_tag        = s3.tag;
  assign out_busy       = s1.vld | s2.vld | s3.vld;

  // Stage valid/tag registers: reset > flush > lockstep shift > lone retire of stage 3.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (in_flush) begin
      s1.vld <= 1'b0;
      s2.vld <= 1'b0;
      s3.vld <= 1'b0;
    end else if (advance) begin
      s1.vld <= in_valid;
      s1.tag <= in_tag;
      s2     <= s1;
      s3     <= s2;
    end else if (s3.vld && in_ready) begin
      s3.vld <= 1'b0;
    end
  end

  // The randomness word must split evenly across the shares.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      assert (RAND_WIDTH % NUM_SHARES == 0);
    end
  end

`ifdef SBOX_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic        stall;

  // Flush cycles are deliberate drops, not stalls, so they are excluded.
  assign stall = shift_needed & ~in_flush & ~advance;

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign out_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_masked_sbox_pipe_ctrl.sv
// Testbench for masked_sbox_pipe_ctrl: vector table plus hand sequences, tag scoreboard.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Define SBOX_CTRL_STALL_CNT_EN to also cover the stall counter.
module tb_masked_sbox_pipe_ctrl;
  localparam int RW = 64;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst, iv, rv, rdy, fl;
  logic [TW-1:0] itag;
  logic [RW-1:0] rnd;
  logic          o_in_ready, o_rand_ready, o_en, o_valid, o_busy;
  logic [RW-1:0] o_random;
  logic [TW-1:0] o_tag;
`ifdef SBOX_CTRL_STALL_CNT_EN
  logic [15:0]   o_stall;
  logic [15:0]   stall_ref;
`endif

  masked_sbox_pipe_ctrl #(.NUM_SHARES(2), .RAND_WIDTH(RW), .TAG_WIDTH(TW)) dut (
    .in_clock(clk), .in_reset(rst), .in_valid(iv), .out_in_ready(o_in_ready),
    .in_tag(itag), .in_rand_valid(rv), .out_rand_ready(o_rand_ready),
    .in_rand(rnd), .out_random(o_random), .out_stage_en(o_en),
    .out_valid(o_valid), .in_ready(rdy), .out_tag(o_tag),
    .in_flush(fl), .out_busy(o_busy)
`ifdef SBOX_CTRL_STALL_CNT_EN
    , .out_stall_cnt(o_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, rand_cnt = 0;
  logic [TW-1:0] sbq[$];
  int retire_cyc[$];

  typedef struct {
    logic          iv;
    logic [TW-1:0] tag;
    logic          rv, rdy;
    logic          en, ov, busy, chk_tag;
    logic [TW-1:0] otag;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle with the inputs already driven; scoreboard updated at the sample point.
  task automatic step();
    rnd = {$urandom, $urandom};
    #1;
    chk("random_passthru", o_random, rnd);
    if (rst || fl) begin
      sbq.delete();
    end else begin
      if (o_valid && rdy) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got tag %0h expected no result (cycle %0d)", o_tag, cyc);
        end else begin
          total--;
          chk("sb_tag", o_tag, sbq.pop_front());
        end
        retire_cyc.push_back(cyc);
      end
      if (iv && o_in_ready) sbq.push_back(itag);
    end
    if (o_rand_ready) rand_cnt++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic vec_t mk(logic i_v, logic [TW-1:0] t, logic r_v, logic r_dy,
                              logic e, logic o, logic b, logic c, logic [TW-1:0] ot);
    vec_t v;
    v.iv = i_v; v.tag = t; v.rv = r_v; v.rdy = r_dy;
    v.en = e; v.ov = o; v.busy = b; v.chk_tag = c; v.otag = ot;
    return v;
  endfunction

  task automatic run_vec(input int i);
    iv = vt[i].iv; itag = vt[i].tag; rv = vt[i].rv; rdy = vt[i].rdy; fl = 1'b0;
    #1;
    chk("vec_en", o_en, vt[i].en);
    chk("vec_valid", o_valid, vt[i].ov);
    chk("vec_busy", o_busy, vt[i].busy);
    if (vt[i].chk_tag) chk("vec_tag", o_tag, vt[i].otag);
    step();
  endtask

  initial begin
    int first, n;
    logic seen;
    //                 iv  tag    rv  rdy   en  ov  busy chk otag
    vt[0]  = mk(1, 4'h5, 1, 1,  1, 0, 0, 0, 4'h0); // single byte accepted
    vt[1]  = mk(0, 4'h0, 1, 1,  1, 0, 1, 0, 4'h0);
    vt[2]  = mk(0, 4'h0, 1, 1,  1, 0, 1, 0, 4'h0);
    vt[3]  = mk(0, 4'h0, 1, 1,  0, 1, 1, 1, 4'h5); // k+3: result, no enable
    vt[4]  = mk(0, 4'h0, 1, 1,  0, 0, 0, 1, 4'h5); // retired, tag held
    vt[5]  = mk(1, 4'hA, 1, 1,  1, 0, 0, 1, 4'h5);
    vt[6]  = mk(1, 4'hB, 1, 1,  1, 0, 1, 0, 4'h0);
    vt[7]  = mk(0, 4'h0, 0, 1,  0, 0, 1, 0, 4'h0); // PRNG starved x4
    vt[8]  = mk(0, 4'h0, 0, 1,  0, 0, 1, 0, 4'h0);
    vt[9]  = mk(0, 4'h0, 0, 1,  0, 0, 1, 0, 4'h0);
    vt[10] = mk(0, 4'h0, 0, 1,  0, 0, 1, 0, 4'h0);
    vt[11] = mk(0, 4'h0, 1, 1,  1, 0, 1, 0, 4'h0);
    vt[12] = mk(0, 4'h0, 1, 1,  1, 1, 1, 1, 4'hA);
    vt[13] = mk(0, 4'h0, 1, 1,  0, 1, 1, 1, 4'hB);
    vt[14] = mk(0, 4'h0, 1, 1,  0, 0, 0, 0, 4'h0);

    rst = 1'b1; iv = 1'b0; rv = 1'b1; rdy = 1'b1; fl = 1'b0; itag = '0; rnd = '0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_en", o_en, 1'b0);
    chk("rst_rand_ready", o_rand_ready, 1'b0);
    chk("rst_in_ready", o_in_ready, 1'b0);
    chk("rst_tag", o_tag, 4'h0);
`ifdef SBOX_CTRL_STALL_CNT_EN
    chk("rst_stall", o_stall, 16'd0);
`endif

    // Single byte and PRNG starvation from the table.
    rand_cnt = 0;
    for (int i = 0; i < 5; i++) run_vec(i);
    chk("single_rand_words", rand_cnt, 3);
    for (int i = 5; i < 15; i++) run_vec(i);
    chk("starve_rand_words", rand_cnt, 7);
`ifdef SBOX_CTRL_STALL_CNT_EN
    chk("starve_stall_cnt", o_stall, 16'd4);
`endif

    // Back-to-back stream of 16 tags.
    rand_cnt = 0; retire_cyc.delete(); first = cyc;
    rv = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iv = 1'b1; itag = TW'(i);
      step();
    end
    iv = 1'b0; itag = '0;
    n = 0;
    while (o_busy && n < 20) begin step(); n++; end
    chk("stream_drained", o_busy, 1'b0);
    chk("stream_rand_words", rand_cnt, 18);
    chk("stream_retire_count", retire_cyc.size(), 16);
    if (retire_cyc.size() == 16)
      for (int j = 0; j < 16; j++) chk("stream_retire_cycle", retire_cyc[j], first + 3 + j);

    // Output backpressure with a full pipe.
`ifdef SBOX_CTRL_STALL_CNT_EN
    stall_ref = o_stall;
`endif
    rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin iv = 1'b1; itag = TW'(i); step(); end
    rand_cnt = 0;
    iv = 1'b1; itag = 4'h4;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_en", o_en, 1'b0);
      chk("bp_in_ready", o_in_ready, 1'b0);
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_tag", o_tag, 4'h1);
      step();
    end
    chk("bp_rand_words", rand_cnt, 0);
`ifdef SBOX_CTRL_STALL_CNT_EN
    chk("bp_stall_cnt", o_stall, stall_ref + 16'd5);
`endif
    iv = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_release_valid", o_valid, 1'b1);
      step();
    end
    chk("bp_release_empty", o_busy, 1'b0);

    // Flush with a full pipe and a byte on offer.
    for (int i = 7; i <= 9; i++) begin iv = 1'b1; itag = TW'(i); step(); end
`ifdef SBOX_CTRL_STALL_CNT_EN
    stall_ref = o_stall;
`endif
    iv = 1'b1; itag = 4'hA; fl = 1'b1;
    #1;
    chk("flush_busy_before", o_busy, 1'b1);
    chk("flush_rand_ready", o_rand_ready, 1'b0);
    chk("flush_in_ready", o_in_ready, 1'b0);
    step();
    fl = 1'b0; iv = 1'b0;
    #1;
    chk("flush_busy_after", o_busy, 1'b0);
    chk("flush_valid_after", o_valid, 1'b0);
`ifdef SBOX_CTRL_STALL_CNT_EN
    chk("flush_stall_cnt", o_stall, stall_ref);
`endif
    step();

    // Reset mid-stream.
    for (int i = 1; i <= 2; i++) begin iv = 1'b1; itag = TW'(i); step(); end
    rst = 1'b1; iv = 1'b1; itag = 4'h3;
    step();
    rst = 1'b0; iv = 1'b0; itag = '0;
    #1;
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_en", o_en, 1'b0);
    chk("mid_rst_rand_ready", o_rand_ready, 1'b0);
    chk("mid_rst_in_ready", o_in_ready, 1'b0);
    chk("mid_rst_tag", o_tag, 4'h0);
`ifdef SBOX_CTRL_STALL_CNT_EN
    chk("mid_rst_stall", o_stall, 16'd0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (o_valid) seen = 1'b1;
      step();
    end
    chk("mid_rst_no_output", seen, 1'b0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/masked_sbox_pipe_ctrl.md
# masked_sbox_pipe_ctrl

Lockstep controller for the three-stage masked GF(2^8) inverse / S-box pipeline (stage 1, stage 2 HPC3 multipliers plus theta, stage 3). It owns the single datapath clock enable, meters fresh randomness from the PRNG through a valid/ready handshake so that no gadget register ever captures stale or reused masks, tracks per-stage valid bits and a side-band tag, and presents a valid/ready interface upstream and downstream.

## Interface
- NUM_SHARES, 2: share count; forwarded only for randomness width.
- RAND_WIDTH, 64: fresh random bits consumed per datapath advance, covering all three stages.
- TAG_WIDTH, 4: side-band tag carried with each byte, for example the state byte index.
- in_clock  input  1  clock; single clock domain.
- in_reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream shares valid this cycle.
- out_in_ready  output  1  upstream byte accepted when in_valid && out_in_ready.
- in_tag  input  TAG_WIDTH  tag of the offered byte.
- in_rand_valid  input  1  PRNG word available.
- out_rand_ready  output  1  PRNG word consumed this cycle.
- in_rand  input  RAND_WIDTH  PRNG word.
- out_random  output  RAND_WIDTH  randomness to the datapath; equals in_rand, combinational.
- out_stage_en  output  1  datapath register enable for all three stages.
- out_valid  output  1  stage-3 result valid.
- in_ready  input  1  downstream accepts the result.
- out_tag  output  TAG_WIDTH  tag aligned with the stage-3 result.
- in_flush  input  1  synchronous pipeline drop.
- out_busy  output  1  any stage valid.

## Operation
- State per stage i = 1..3: valid bit v_i and tag t_i. The datapath registers hold the shares.
- shift_needed = in_valid | v1 | v2.
- out_sink = !v3 | in_ready.
- advance = shift_needed & in_rand_valid & out_sink & !in_flush.
- out_stage_en = advance, out_rand_ready = advance, out_in_ready = advance.
- A PRNG word is consumed only on advance. Randomness is never consumed for an empty pipeline and never reused across two enables.
- On advance, all of the following happen together:
  - v1 <= in_valid, t1 <= in_tag.
  - v2 <= v1, t2 <= t1.
  - v3 <= v2, t3 <= t2.
- Bubbles (v = 0) propagate and consume randomness whenever a valid byte sits behind them.
- No advance, v3 = 1 and in_ready = 1: v3 <= 0, result retired, tags unchanged.
- No advance otherwise: all state holds and out_valid/out_tag stay stable (no retraction).
- out_valid = v3, out_tag = t3, out_busy = v1 | v2 | v3.
- in_flush: all v_i <= 0 next cycle. Tags hold, in_valid is not accepted and no randomness is consumed that cycle. Flush has priority over every other event.
- in_reset: all v_i <= 0, all t_i <= 0, stall counter <= 0. Reset overrides flush.

## Timing
- Reset values, combinational outputs: out_valid, out_busy, out_stage_en, out_rand_ready and out_in_ready are 0 the cycle after reset.
- Reset values, registered outputs: out_tag = 0.
- Latency: a byte accepted in cycle k (clean pipe, PRNG always valid, in_ready = 1) gives out_valid = 1 in cycle k+3.
- Throughput: one byte per cycle.
- Simultaneous events, all resolved in the same cycle:
  - Retire plus accept: v3 = 1, in_ready = 1 and advance → v3 is replaced by v2.
  - PRNG starvation: in_rand_valid = 0 → no enable. v3 may still retire.
  - Output backpressure: v3 = 1, in_ready = 0 → full stall even when the PRNG is valid.
- Drain: with in_valid = 0, the pipe advances while v1 | v2 is set, then holds v3 alone.
- Reset mid-operation drops every in-flight byte with no output.

## Configuration
- SBOX_CTRL_STALL_CNT_EN
- Defined: adds output out_stall_cnt [15:0], which counts cycles where shift_needed = 1 but advance = 0 because of PRNG starvation or output backpressure.
  - The counter saturates at 16'hFFFF.
  - It clears on in_reset only; flush does not clear it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Single byte, PRNG always valid, in_ready = 1: in_tag = 4'h5 accepted at cycle 10 → out_valid = 1, out_tag = 4'h5 at cycle 13. out_stage_en is high in cycles 10–12 only, and exactly 3 PRNG words are consumed.
- Back-to-back stream of 16 tags 0..15 → out_tag = 0..15 on consecutive cycles starting 3 cycles after the first accept. out_rand_ready is high for 18 cycles in total.
- PRNG starvation: drop in_rand_valid for 4 cycles while v1 = v2 = 1 → out_stage_en = 0 and state frozen for those 4 cycles. With the macro defined, out_stall_cnt increases by 4. Order is preserved.
- Backpressure: hold in_ready = 0 for 5 cycles with a full pipe → out_valid and out_tag stay stable, out_in_ready = 0 and no randomness is consumed. Releasing in_ready retires one result per cycle.
- Flush with v1 = v2 = v3 = 1 and in_valid = 1 → next cycle out_busy = 0 and out_valid = 0. That cycle out_rand_ready = 0 and out_in_ready = 0.
- Reset asserted mid-stream while in_rand_valid = 1 → cycle after reset: all outputs at their reset values, and no result ever appears for the dropped bytes.
